// File: rtl/alarm_pkg.sv
// Shared types, reset constants and BCD increment helpers for the multi-alarm clock.
// The time_t struct carries the pm flag so a single equality compares the full time.
package alarm_pkg;

    localparam int HT_W = 2;
    localparam int HU_W = 4;
    localparam int MT_W = 3;
    localparam int MU_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RING = 2'd1,
        ST_SNZ  = 2'd2
    } state_e;

    typedef struct packed {
        logic            pm;
        logic [HT_W-1:0] hourten;
        logic [HU_W-1:0] hour;
        logic [MT_W-1:0] minten;
        logic [MU_W-1:0] min;
    } time_t;

    localparam time_t TIME_RST_24 = '{pm: 1'b0, hourten: 2'd0, hour: 4'd0, minten: 3'd0, min: 4'd0};
    localparam time_t TIME_RST_12 = '{pm: 1'b0, hourten: 2'd1, hour: 4'd2, minten: 3'd0, min: 4'd0};
    localparam time_t ALARM_RST   = '{pm: 1'b0, hourten: 2'd0, hour: 4'd6, minten: 3'd0, min: 4'd0};

    // Minute +1 wrapping 59 -> 00; the hour field is untouched.
    function automatic time_t bcd_min_inc(input time_t t);
        time_t r;
        r = t;
        if (t.min == 4'd9) begin
            r.min    = 4'd0;
            r.minten = (t.minten == 3'd5) ? 3'd0 : t.minten + 3'd1;
        end else begin
            r.min = t.min + 4'd1;
        end
        return r;
    endfunction

    // Hour +1: 23 -> 00 in 24h mode; 12 -> 01 and 11 -> 12 (toggling pm) in 12h mode.
    function automatic time_t bcd_hour_inc(input time_t t, input logic mode_24h);
        time_t r;
        r = t;
        if (mode_24h) begin
            if (t.hourten == 2'd2 && t.hour == 4'd3) begin
                r.hourten = 2'd0;
                r.hour    = 4'd0;
            end else if (t.hour == 4'd9) begin
                r.hourten = t.hourten + 2'd1;
                r.hour    = 4'd0;
            end else begin
                r.hour = t.hour + 4'd1;
            end
        end else begin
            if (t.hourten == 2'd1 && t.hour == 4'd2) begin
                r.hourten = 2'd0;
                r.hour    = 4'd1;
            end else if (t.hourten == 2'd1 && t.hour == 4'd1) begin
                r.hour = 4'd2;
                r.pm   = ~t.pm;
            end else if (t.hour == 4'd9) begin
                r.hourten = 2'd1;
                r.hour    = 4'd0;
            end else begin
                r.hour = t.hour + 4'd1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/alarm_channel.sv
// One alarm channel: settable alarm time, comparator against the running time,
// and the IDLE/RING/SNZ state machine with its ring, snooze and snooze-use counters.
module alarm_channel
    import alarm_pkg::*;
#(
    parameter bit          MODE_24H    = 1'b1,
    parameter int unsigned RING_CYCLES = 5,
    parameter int unsigned SNOOZE_MIN  = 5,
    parameter int unsigned MAX_SNOOZE  = 3
) (
    input  logic  clk_1Hz,
    input  logic  rst,
    input  logic  advance_i,
    input  logic  set_mode_i,
    input  logic  sel_hit_i,
    input  logic  inc_min_i,
    input  logic  inc_hour_i,
    input  logic  en_i,
    input  logic  snooze_i,
    input  logic  dismiss_i,
    input  time_t time_i,
    output time_t alarm_o,
    output logic  ringing_o
);

    localparam logic [3:0] RING_LD = 4'(RING_CYCLES);
    localparam logic [3:0] SNZ_LD  = 4'(SNOOZE_MIN);
    localparam logic [2:0] SNZ_MAX = 3'(MAX_SNOOZE);

    time_t      alarm_q, alarm_d;
    state_e     state_q;
    logic [3:0] ring_cnt_q;
    logic [3:0] snz_cnt_q;
    logic [2:0] snz_used_q;
    logic       ringing_q;
    logic       match;

    always_comb begin
        // NOTE: alarm_d takes a default first so no path leaves it unassigned (no latch).
        alarm_d = alarm_q;
        if (set_mode_i && sel_hit_i) begin
            if (inc_min_i) begin
                alarm_d = bcd_min_inc(alarm_q);
            end else if (inc_hour_i) begin
                alarm_d = bcd_hour_inc(alarm_q, MODE_24H);
            end
        end
    end

    always_ff @(posedge clk_1Hz) begin
        // NOTE: non-blocking assignments make every register sample pre-edge values.
        if (rst) alarm_q <= ALARM_RST;
        else     alarm_q <= alarm_d;
    end

    assign match = advance_i && en_i && (time_i == alarm_q);

    always_ff @(posedge clk_1Hz) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ring_cnt_q <= '0;
            snz_cnt_q  <= '0;
            snz_used_q <= '0;
            ringing_q  <= 1'b0;
        end else if (dismiss_i || !en_i || set_mode_i) begin
            state_q    <= ST_IDLE;
            snz_used_q <= '0;
            ringing_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (match) begin
                        state_q    <= ST_RING;
                        ring_cnt_q <= RING_LD;
                        snz_used_q <= '0;
                        ringing_q  <= 1'b1;
                    end
                end
                ST_RING: begin
                    if (snooze_i) begin
                        ringing_q <= 1'b0;
                        if (snz_used_q < SNZ_MAX) begin
                            state_q    <= ST_SNZ;
                            snz_cnt_q  <= SNZ_LD;
                            snz_used_q <= snz_used_q + 3'd1;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else if (ring_cnt_q == 4'd1) begin
                        state_q   <= ST_IDLE;
                        ringing_q <= 1'b0;
                    end else begin
                        ring_cnt_q <= ring_cnt_q - 4'd1;
                    end
                end
                ST_SNZ: begin
                    // A fresh match re-rings early but keeps the snooze count of this trigger.
                    if (match || (advance_i && snz_cnt_q == 4'd1)) begin
                        state_q    <= ST_RING;
                        ring_cnt_q <= RING_LD;
                        ringing_q  <= 1'b1;
                    end else if (advance_i) begin
                        snz_cnt_q <= snz_cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    ringing_q <= 1'b0;
                end
            endcase
        end
    end

    assign alarm_o   = alarm_q;
    assign ringing_o = ringing_q;

endmodule

// File: rtl/multi_alarm_clock.sv
// BCD time-of-day counter with NUM_ALARMS alarm channels, display mux and ring LED.
// Time advances one minute per clk_1Hz cycle while run=1 and set_mode=0.
module multi_alarm_clock
    import alarm_pkg::*;
#(
    parameter int unsigned NUM_ALARMS  = 4,
    parameter bit          MODE_24H    = 1'b1,
    parameter int unsigned RING_CYCLES = 5,
    parameter int unsigned SNOOZE_MIN  = 5,
    parameter int unsigned MAX_SNOOZE  = 3,
    localparam int         SEL_W       = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic                  clk_1Hz,
    input  logic                  rst,
    input  logic                  run,
    input  logic                  set_mode,
    input  logic [SEL_W-1:0]      sel,
    input  logic                  inc_min,
    input  logic                  inc_hour,
    input  logic [NUM_ALARMS-1:0] alarm_en,
    input  logic                  snooze,
    input  logic                  dismiss,
    output logic [HT_W-1:0]       hourten,
    output logic [HU_W-1:0]       hour,
    output logic [MT_W-1:0]       minten,
    output logic [MU_W-1:0]       min,
    output logic                  pm,
    output logic [NUM_ALARMS-1:0] ringing,
    output logic                  led
);

    localparam time_t TIME_RST = MODE_24H ? TIME_RST_24 : TIME_RST_12;

    time_t                 time_q, time_d;
    time_t                 disp;
    time_t                 alarm_w [NUM_ALARMS];
    logic [NUM_ALARMS-1:0] ring_w;
    logic                  advance;

    assign advance = run && !set_mode;

    always_comb begin
        time_d = time_q;
        if (advance) begin
            time_d = bcd_min_inc(time_q);
            if (time_q.minten == 3'd5 && time_q.min == 4'd9) begin
                time_d = bcd_hour_inc(time_d, MODE_24H);
            end
        end
    end

    always_ff @(posedge clk_1Hz) begin
        if (rst) time_q <= TIME_RST;
        else     time_q <= time_d;
    end

    for (genvar k = 0; k < NUM_ALARMS; k++) begin : g_ch
        alarm_channel #(
            .MODE_24H   (MODE_24H),
            .RING_CYCLES(RING_CYCLES),
            .SNOOZE_MIN (SNOOZE_MIN),
            .MAX_SNOOZE (MAX_SNOOZE)
        ) u_ch (
            .clk_1Hz   (clk_1Hz),
            .rst       (rst),
            .advance_i (advance),
            .set_mode_i(set_mode),
            .sel_hit_i (sel == SEL_W'(k)),
            .inc_min_i (inc_min),
            .inc_hour_i(inc_hour),
            .en_i      (alarm_en[k]),
            .snooze_i  (snooze),
            .dismiss_i (dismiss),
            .time_i    (time_q),
            .alarm_o   (alarm_w[k]),
            .ringing_o (ring_w[k])
        );
    end

    // Display is a pure mux of registers, so no input reaches the outputs combinationally
    // except through set_mode/sel selecting which register is shown.
    always_comb begin
        disp = time_q;
        if (set_mode) begin
            for (int k = 0; k < NUM_ALARMS; k++) begin
                if (sel == SEL_W'(k)) disp = alarm_w[k];
            end
        end
    end

    assign hourten = disp.hourten;
    assign hour    = disp.hour;
    assign minten  = disp.minten;
    assign min     = disp.min;
    assign pm      = MODE_24H ? 1'b0 : disp.pm;
    assign ringing = ring_w;
    assign led     = |ring_w;

endmodule

// File: tb/tb_multi_alarm_clock.sv
// Scoreboard bench for multi_alarm_clock: a 24h instance under full test and a 12h
// instance sharing its inputs for 12h wrap and alarm-set checks.
module tb_multi_alarm_clock;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, run, set_mode, inc_min, inc_hour, snooze, dismiss;
    logic [1:0] sel;
    logic [3:0] alarm_en;

    logic [1:0] hourten, hourten12;
    logic [3:0] hour, hour12, min, min12;
    logic [2:0] minten, minten12;
    logic       pm, pm12, led, led12;
    logic [3:0] ringing, ringing12;
    logic [15:0] disp, disp12;

    assign disp   = {2'b00, hourten, hour, 1'b0, minten, min};
    assign disp12 = {2'b00, hourten12, hour12, 1'b0, minten12, min12};

    multi_alarm_clock #(.NUM_ALARMS(4), .MODE_24H(1'b1)) dut (
        .clk_1Hz(clk), .rst(rst), .run(run), .set_mode(set_mode), .sel(sel),
        .inc_min(inc_min), .inc_hour(inc_hour), .alarm_en(alarm_en),
        .snooze(snooze), .dismiss(dismiss),
        .hourten(hourten), .hour(hour), .minten(minten), .min(min), .pm(pm),
        .ringing(ringing), .led(led)
    );

    multi_alarm_clock #(.NUM_ALARMS(4), .MODE_24H(1'b0)) dut12 (
        .clk_1Hz(clk), .rst(rst), .run(run), .set_mode(set_mode), .sel(sel),
        .inc_min(inc_min), .inc_hour(inc_hour), .alarm_en(alarm_en),
        .snooze(snooze), .dismiss(dismiss),
        .hourten(hourten12), .hour(hour12), .minten(minten12), .min(min12), .pm(pm12),
        .ringing(ringing12), .led(led12)
    );

    typedef struct {
        string       tag;
        logic [15:0] disp;
        logic [3:0]  ring;
        logic        chk12;
        logic [15:0] disp12;
        logic        pm12;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic void push(input string tag, input logic [15:0] d, input logic [3:0] r,
                                 input logic c12, input logic [15:0] d12, input logic p12);
        exp_t e;
        e.tag = tag; e.disp = d; e.ring = r; e.chk12 = c12; e.disp12 = d12; e.pm12 = p12;
        sb.push_back(e);
    endfunction

    function automatic logic [15:0] bcd16(input int m);
        return {8'h00, 4'(m / 10), 4'(m % 10)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; run = 1'b0; set_mode = 1'b0; inc_min = 1'b0; inc_hour = 1'b0;
        snooze = 1'b0; dismiss = 1'b0; sel = 2'd0; alarm_en = 4'b0000;
        tick();
        rst = 1'b0;
    endtask

    task automatic set_alarm(input logic [1:0] s, input int nh, input int nm);
        set_mode = 1'b1; sel = s;
        inc_hour = 1'b1; repeat (nh) tick(); inc_hour = 1'b0;
        inc_min  = 1'b1; repeat (nm) tick(); inc_min  = 1'b0;
        set_mode = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        do_reset();
        push("reset_time", 16'h0000, 4'b0000, 1'b1, 16'h1200, 1'b0);
        e = sb.pop_front();
        n_tests++;
        if ({disp, pm, ringing, led} !== {e.disp, 1'b0, e.ring, |e.ring} ||
            (e.chk12 && {disp12, pm12, ringing12, led12} !== {e.disp12, e.pm12, 5'b0})) begin
            n_fail++;
            $display("FAIL %s: got %h pm=%b ring=%b led=%b t12=%h/%b, expected %h ring=%b t12=%h/%b",
                     e.tag, disp, pm, ringing, led, disp12, pm12, e.disp, e.ring, e.disp12, e.pm12);
        end
        set_mode = 1'b1;
        for (int k = 0; k < 4; k++) begin
            sel = 2'(k);
            #1;
            push($sformatf("reset_alarm%0d", k), 16'h0600, 4'b0000, 1'b1, 16'h0600, 1'b0);
            e = sb.pop_front();
            n_tests++;
            if ({disp, pm, ringing} !== {e.disp, 1'b0, e.ring} ||
                (e.chk12 && {disp12, pm12} !== {e.disp12, e.pm12})) begin
                n_fail++;
                $display("FAIL %s: got %h t12=%h/%b, expected %h t12=%h/%b",
                         e.tag, disp, disp12, pm12, e.disp, e.disp12, e.pm12);
            end
        end
        set_mode = 1'b0;
    endtask

    task automatic test_time_wrap();
        int          cp   [10] = '{10, 59, 60, 600, 719, 720, 780, 1438, 1439, 1440};
        logic [15:0] e24  [10] = '{16'h0010, 16'h0059, 16'h0100, 16'h1000, 16'h1159,
                                   16'h1200, 16'h1300, 16'h2358, 16'h2359, 16'h0000};
        logic [15:0] e12  [10] = '{16'h1210, 16'h1259, 16'h0100, 16'h1000, 16'h1159,
                                   16'h1200, 16'h0100, 16'h1158, 16'h1159, 16'h1200};
        logic        ep12 [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        int j = 0;
        exp_t e;
        do_reset();
        for (int i = 0; i < 10; i++)
            push($sformatf("wrap_min%0d", cp[i]), e24[i], 4'b0000, 1'b1, e12[i], ep12[i]);
        run = 1'b1;
        for (int c = 1; c <= 1440; c++) begin
            tick();
            if (j < 10 && c == cp[j]) begin
                j++;
                e = sb.pop_front();
                n_tests++;
                if ({disp, pm, ringing} !== {e.disp, 1'b0, e.ring} ||
                    (e.chk12 && {disp12, pm12} !== {e.disp12, e.pm12})) begin
                    n_fail++;
                    $display("FAIL %s: got %h pm=%b t12=%h/%b, expected %h t12=%h/%b",
                             e.tag, disp, pm, disp12, pm12, e.disp, e.disp12, e.pm12);
                end
            end
        end
        run = 1'b0;
    endtask

    task automatic test_alarm_set();
        exp_t e;
        do_reset();
        run = 1'b1;
        set_mode = 1'b1; sel = 2'd2;
        for (int step = 0; step < 8; step++) begin
            case (step)
                0: begin inc_hour = 1'b1; repeat (3) tick(); inc_hour = 1'b0;
                         push("set_3h", 16'h0900, 4'b0, 1'b1, 16'h0900, 1'b0); end
                1: begin inc_min = 1'b1; repeat (7) tick(); inc_min = 1'b0;
                         push("set_7m", 16'h0907, 4'b0, 1'b1, 16'h0907, 1'b0); end
                2: begin inc_min = 1'b1; inc_hour = 1'b1; tick(); inc_min = 1'b0; inc_hour = 1'b0;
                         push("set_both", 16'h0908, 4'b0, 1'b1, 16'h0908, 1'b0); end
                3: begin inc_hour = 1'b1; repeat (3) tick(); inc_hour = 1'b0;
                         push("set_to_12", 16'h1208, 4'b0, 1'b1, 16'h1208, 1'b1); end
                4: begin inc_hour = 1'b1; repeat (12) tick(); inc_hour = 1'b0;
                         push("set_hour_wrap", 16'h0008, 4'b0, 1'b1, 16'h1208, 1'b0); end
                5: begin inc_min = 1'b1; repeat (52) tick(); inc_min = 1'b0;
                         push("set_min_wrap", 16'h0000, 4'b0, 1'b1, 16'h1200, 1'b0); end
                6: begin sel = 2'd1; #1;
                         push("set_other_sel", 16'h0600, 4'b0, 1'b1, 16'h0600, 1'b0); end
                default: begin set_mode = 1'b0; #1;
                         push("set_time_frozen", 16'h0000, 4'b0, 1'b1, 16'h1200, 1'b0); end
            endcase
            e = sb.pop_front();
            n_tests++;
            if ({disp, pm, ringing} !== {e.disp, 1'b0, e.ring} ||
                (e.chk12 && {disp12, pm12} !== {e.disp12, e.pm12})) begin
                n_fail++;
                $display("FAIL %s: got %h pm=%b t12=%h/%b, expected %h t12=%h/%b",
                         e.tag, disp, pm, disp12, pm12, e.disp, e.disp12, e.pm12);
            end
        end
        push("run_after_set", 16'h0001, 4'b0, 1'b1, 16'h1201, 1'b0);
        tick();
        e = sb.pop_front();
        n_tests++;
        if ({disp, pm} !== {e.disp, 1'b0} || {disp12, pm12} !== {e.disp12, e.pm12}) begin
            n_fail++;
            $display("FAIL %s: got %h t12=%h/%b, expected %h t12=%h/%b",
                     e.tag, disp, disp12, pm12, e.disp, e.disp12, e.pm12);
        end
        run = 1'b0;
    endtask

    task automatic test_ring();
        exp_t e;
        do_reset();
        set_alarm(2'd0, 18, 3);
        alarm_en = 4'b0001; run = 1'b1;
        for (int c = 1; c <= 10; c++)
            push($sformatf("ring_c%0d", c), bcd16(c), (c >= 4 && c <= 8) ? 4'b0001 : 4'b0000, 1'b0, 16'h0, 1'b0);
        for (int c = 1; c <= 10; c++) begin
            tick();
            e = sb.pop_front();
            n_tests++;
            if ({disp, pm, ringing, led} !== {e.disp, 1'b0, e.ring, |e.ring}) begin
                n_fail++;
                $display("FAIL %s: got %h ring=%b led=%b, expected %h ring=%b",
                         e.tag, disp, ringing, led, e.disp, e.ring);
            end
        end
        run = 1'b0; alarm_en = 4'b0000;
    endtask

    task automatic test_snooze();
        exp_t e;
        logic on;
        do_reset();
        set_alarm(2'd0, 18, 3);
        alarm_en = 4'b0001; run = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            on = (c == 4 || c == 5 || c == 11 || c == 12 || c == 18 || c == 19 || c == 25 || c == 26);
            push($sformatf("snooze_c%0d", c), bcd16(c), {3'b000, on}, 1'b0, 16'h0, 1'b0);
        end
        for (int c = 1; c <= 40; c++) begin
            tick();
            e = sb.pop_front();
            n_tests++;
            if ({disp, ringing, led} !== {e.disp, e.ring, |e.ring}) begin
                n_fail++;
                $display("FAIL %s: got %h ring=%b led=%b, expected %h ring=%b",
                         e.tag, disp, ringing, led, e.disp, e.ring);
            end
            snooze = (c == 5 || c == 12 || c == 19 || c == 26);
        end
        snooze = 1'b0; run = 1'b0; alarm_en = 4'b0000;
    endtask

    task automatic test_dismiss();
        exp_t e;
        for (int part = 0; part < 2; part++) begin
            do_reset();
            set_alarm(2'd0, 18, 2);
            set_alarm(2'd1, 18, 2);
            alarm_en = 4'b0011; run = 1'b1;
            for (int c = 1; c <= 12; c++) begin
                if (part == 0)
                    push($sformatf("dismiss_c%0d", c), bcd16(c),
                         (c == 3 || c == 4) ? 4'b0011 : 4'b0000, 1'b0, 16'h0, 1'b0);
                else
                    push($sformatf("disable1_c%0d", c), bcd16(c),
                         (c == 3 || c == 4) ? 4'b0011 : (c >= 5 && c <= 7) ? 4'b0001 : 4'b0000,
                         1'b0, 16'h0, 1'b0);
            end
            for (int c = 1; c <= 12; c++) begin
                tick();
                e = sb.pop_front();
                n_tests++;
                if ({disp, ringing, led} !== {e.disp, e.ring, |e.ring}) begin
                    n_fail++;
                    $display("FAIL %s: got %h ring=%b led=%b, expected %h ring=%b",
                             e.tag, disp, ringing, led, e.disp, e.ring);
                end
                if (part == 0) dismiss = (c == 4);
                else if (c == 4) alarm_en = 4'b0001;
            end
            dismiss = 1'b0; run = 1'b0; alarm_en = 4'b0000;
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int   rc;
        for (int part = 0; part < 2; part++) begin
            rc = (part == 0) ? 4 : 5;
            do_reset();
            set_alarm(2'd0, 18, 2);
            alarm_en = 4'b0001; run = 1'b1;
            for (int c = 1; c <= 15; c++)
                push($sformatf("rst_%s_c%0d", (part == 0) ? "ring" : "snz", c),
                     (c <= rc) ? bcd16(c) : bcd16(c - rc - 1),
                     ((part == 0 && (c == 3 || c == 4)) || (part == 1 && c == 3)) ? 4'b0001 : 4'b0000,
                     1'b0, 16'h0, 1'b0);
            for (int c = 1; c <= 15; c++) begin
                tick();
                e = sb.pop_front();
                n_tests++;
                if ({disp, pm, ringing, led} !== {e.disp, 1'b0, e.ring, |e.ring}) begin
                    n_fail++;
                    $display("FAIL %s: got %h ring=%b led=%b, expected %h ring=%b",
                             e.tag, disp, ringing, led, e.disp, e.ring);
                end
                snooze = (part == 1 && c == 3);
                rst    = (c == rc);
            end
            rst = 1'b0; snooze = 1'b0; run = 1'b0; alarm_en = 4'b0000;
        end
    endtask

    initial begin
        test_reset();
        test_time_wrap();
        test_alarm_set();
        test_ring();
        test_snooze();
        test_dismiss();
        test_reset_mid();
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_leftover: %0d entries remain, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
